// File: rtl/string_run_encoder.sv
// Run-length encoder for wide symbols: collapses consecutive equal symbols into
// {symbol, count} records and queues them in a small FIFO for the consumer.
module string_run_encoder #(
  parameter int SYM_W = 128,
  parameter int CNT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [SYM_W+CNT_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = SYM_W + CNT_W;
  localparam logic [AW:0]      FULL    = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      occ_q;
  logic             accept, pop, push;
  logic [RW-1:0]    push_rec;

  // Flow control looks only at registered occupancy, so a pop in the same
  // cycle does not open a slot until the following cycle.
  assign in_ready  = !reset && !flush && (occ_q < FULL);
  assign accept    = in_valid && in_ready;
  assign out_valid = !reset && (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign busy      = !reset && ((state_q == RUN) || (occ_q != '0));

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_rec = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sym_d   = in_sym;
          cnt_d   = CNT_ONE;
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (in_sym == sym_q) begin
            // A saturated run is closed and a fresh run of the same symbol opened.
            if (cnt_q == CNT_MAX) begin
              push     = 1'b1;
              push_rec = {sym_q, CNT_MAX};
              cnt_d    = CNT_ONE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            push     = 1'b1;
            push_rec = {sym_q, cnt_q};
            sym_d    = in_sym;
            cnt_d    = CNT_ONE;
          end
        end else if (flush && (occ_q < FULL)) begin
          push     = 1'b1;
          push_rec = {sym_q, cnt_q};
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_rec;
  end

endmodule

// File: tb/tb_string_run_encoder.sv
// Self-checking bench for string_run_encoder: a default-sized instance plus a
// narrow-count instance for saturation; records are checked via scoreboards.
module tb_string_run_encoder;

  localparam int SW  = 128;
  localparam int CW  = 32;
  localparam int RW  = SW + CW;
  localparam int SW2 = 8;
  localparam int CW2 = 2;
  localparam int RW2 = SW2 + CW2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [SW-1:0] in_sym;
  logic          in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [RW-1:0] out_data;

  logic [SW2-1:0] in_sym2;
  logic           in_valid2, in_ready2, flush2, out_valid2, out_ready2, busy2;
  logic [RW2-1:0] out_data2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0]  q1 [$];
  logic [RW2-1:0] q2 [$];
  logic [RW-1:0]  exp1;
  logic [RW2-1:0] exp2;

  string_run_encoder #(.SYM_W(SW), .CNT_W(CW), .DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_sym(in_sym), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  string_run_encoder #(.SYM_W(SW2), .CNT_W(CW2), .DEPTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_sym(in_sym2), .in_valid(in_valid2),
    .in_ready(in_ready2), .flush(flush2), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .busy(busy2)
  );

  typedef struct {
    logic          v;
    logic [SW-1:0] sym;
    logic          fl;
    logic          exp_rdy;
    logic          exp_busy;
    logic          push;
    logic [SW-1:0] psym;
    int unsigned   pcnt;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [SW-1:0] S(input logic [7:0] c);
    return {16{c}};
  endfunction

  function automatic logic [RW-1:0] rec(input logic [SW-1:0] s, input int unsigned c);
    return {s, c[CW-1:0]};
  endfunction

  function automatic vec_t mk(input logic v, input logic [SW-1:0] s, input logic fl,
                              input logic rdy, input logic bsy, input logic p,
                              input logic [SW-1:0] ps, input int unsigned pc);
    vec_t r;
    r.v = v; r.sym = s; r.fl = fl; r.exp_rdy = rdy; r.exp_busy = bsy;
    r.push = p; r.psym = ps; r.pcnt = pc;
    return r;
  endfunction

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SW-1:0] s, input logic fl, input logic ordy);
    in_valid  = v;
    in_sym    = s;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic drain1();
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && (q1.size() != 0 || busy); k++) tick();
    chk1("drain1_empty", q1.size() == 0, 1'b1);
    chk1("drain1_busy", busy, 1'b0);
  endtask

  // Scoreboard monitors: compare each consumed record with the oldest expected one.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL rec1_unexpected got=%h exp=none", out_data);
      end else begin
        exp1 = q1.pop_front();
        if (out_data !== exp1) begin
          n_fail++;
          $display("FAIL rec1 got=%h exp=%h", out_data, exp1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid2 && out_ready2) begin
      n_tests++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL rec2_unexpected got=%h exp=none", out_data2);
      end else begin
        exp2 = q2.pop_front();
        if (out_data2 !== exp2) begin
          n_fail++;
          $display("FAIL rec2 got=%h exp=%h", out_data2, exp2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [SW-1:0] A, B, C, A2;
    logic [SW-1:0] L [6];
    A  = S(8'h41);
    B  = S(8'h42);
    C  = S(8'h43);
    A2 = A ^ {1'b1, {(SW-1){1'b0}}};
    for (int i = 0; i < 6; i++) L[i] = S(8'(8'h41 + i));

    tbl[0]  = mk(1, A,  0, 1, 0, 0, '0, 0);
    tbl[1]  = mk(1, A,  0, 1, 1, 0, '0, 0);
    tbl[2]  = mk(1, A,  0, 1, 1, 0, '0, 0);
    tbl[3]  = mk(1, B,  0, 1, 1, 1, A,  3);
    tbl[4]  = mk(0, '0, 1, 0, 1, 1, B,  1);
    tbl[5]  = mk(0, '0, 0, 1, 1, 0, '0, 0);
    tbl[6]  = mk(0, '0, 0, 1, 0, 0, '0, 0);
    tbl[7]  = mk(1, C,  1, 0, 0, 0, '0, 0);
    tbl[8]  = mk(0, '0, 0, 1, 0, 0, '0, 0);
    tbl[9]  = mk(1, A,  0, 1, 0, 0, '0, 0);
    tbl[10] = mk(1, A2, 0, 1, 1, 1, A,  1);
    tbl[11] = mk(0, '0, 1, 0, 1, 1, A2, 1);
    tbl[12] = mk(0, '0, 0, 1, 1, 0, '0, 0);
    tbl[13] = mk(0, '0, 0, 1, 0, 0, '0, 0);

    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b1);
    in_valid2 = 1'b0; in_sym2 = '0; flush2 = 1'b0; out_ready2 = 1'b1;
    tick();
    tick();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_out_data", out_data, '0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chk1("post_rst_out_valid", out_valid, 1'b0);
    chk1("post_rst_out_valid2", out_valid2, 1'b0);

    // Table: basic runs, flush, IDLE+flush, full-width symbol compare.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].sym, tbl[i].fl, 1'b1);
      if (tbl[i].push) q1.push_back(rec(tbl[i].psym, tbl[i].pcnt));
      #1;
      chk1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
      chk1($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      tick();
    end
    drain1();

    // FIFO fill with backpressure, then release.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, L[i], 1'b0, 1'b0);
      if (i > 0) q1.push_back(rec(L[i-1], 1));
      #1;
      chk1($sformatf("fill%0d_in_ready", i), in_ready, 1'b1);
      tick();
    end
    drive(1'b1, L[5], 1'b0, 1'b0);
    #1;
    chk1("full_in_ready", in_ready, 1'b0);
    chkw("full_head", out_data, rec(L[0], 1));
    tick();
    chk1("full_in_ready_hold", in_ready, 1'b0);
    chkw("full_head_stable", out_data, rec(L[0], 1));
    out_ready = 1'b1;
    #1;
    chk1("release_in_ready_same", in_ready, 1'b0);
    tick();
    q1.push_back(rec(L[4], 1));
    chk1("release_in_ready_next", in_ready, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    q1.push_back(rec(L[5], 1));
    tick();
    drain1();

    // Flush blocked by a full FIFO until one slot is popped.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, L[i], 1'b0, 1'b0);
      if (i > 0) q1.push_back(rec(L[i-1], 1));
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk1("fflush_in_ready", in_ready, 1'b0);
    tick();
    chk1("fflush_busy", busy, 1'b1);
    chkw("fflush_head", out_data, rec(L[0], 1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    q1.push_back(rec(L[4], 1));
    tick();
    flush = 1'b0;
    #1;
    chk1("fflush_refilled", in_ready, 1'b0);
    chkw("fflush_new_head", out_data, rec(L[1], 1));
    drain1();

    // Reset with a run open and a record queued.
    drive(1'b1, A, 1'b0, 1'b0); tick();
    tick();
    drive(1'b1, B, 1'b0, 1'b0); tick();
    in_valid = 1'b0;
    reset = 1'b1;
    q1.delete();
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk1("after_rst_out_valid", out_valid, 1'b0);
    chk1("after_rst_busy", busy, 1'b0);
    chk1("after_rst_in_ready", in_ready, 1'b1);
    drive(1'b1, C, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    q1.push_back(rec(C, 1));
    tick();
    drain1();

    // Narrow count: A x5 saturates at 3 and starts a new run.
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1; in_sym2 = 8'h41; flush2 = 1'b0; out_ready2 = 1'b1;
      if (i == 3) q2.push_back({8'h41, 2'd3});
      #1;
      chk1($sformatf("sat%0d_in_ready", i), in_ready2, 1'b1);
      tick();
    end
    in_valid2 = 1'b0; flush2 = 1'b1;
    q2.push_back({8'h41, 2'd2});
    tick();
    flush2 = 1'b0;
    for (int k = 0; k < 20 && (q2.size() != 0 || busy2); k++) tick();
    chk1("sat_drain_empty", q2.size() == 0, 1'b1);
    chk1("sat_busy", busy2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/string_run_encoder.md
STRING_RUN_ENCODER -- requirements
Module: string_run_encoder

Interface
REQ-001 SHALL have parameter SYM_W, default 128: width of one input string/symbol.
REQ-002 SHALL have parameter CNT_W, default 32: width of the run-length count field.
REQ-003 SHALL have parameter DEPTH, default 4: output record FIFO depth, power of two, >=2.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_sym  input  SYM_W  symbol offered for encoding.
REQ-007 SHALL have port in_valid  input  1  in_sym valid this cycle.
REQ-008 SHALL have port in_ready  output  1  encoder accepts in_sym this cycle.
REQ-009 SHALL have port flush  input  1  close the open run and emit it.
REQ-010 SHALL have port out_data  output  SYM_W+CNT_W  record: [SYM_W+CNT_W-1:CNT_W]=symbol, [CNT_W-1:0]=run count.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid record.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the record this cycle.
REQ-013 SHALL have port busy  output  1  high while a run is open or the FIFO is non-empty.

Function
REQ-014 SHALL accept a symbol only on a cycle where in_valid and in_ready are both high.
REQ-015 SHALL drive in_ready = !reset && !flush && (FIFO occupancy < DEPTH), occupancy taken from registered state.
REQ-016 SHALL implement states IDLE (no open run) and RUN (open run held in cur_sym/cur_cnt).
REQ-017 IDLE + accept: cur_sym<=in_sym, cur_cnt<=1, go RUN; no record emitted.
REQ-018 RUN + accept, in_sym==cur_sym (full SYM_W compare), cur_cnt<2^CNT_W-1: cur_cnt<=cur_cnt+1.
REQ-019 RUN + accept, in_sym==cur_sym, cur_cnt==2^CNT_W-1: push {cur_sym,2^CNT_W-1}, then cur_cnt<=1, stay RUN (count saturates, never wraps to 0).
REQ-020 RUN + accept, in_sym!=cur_sym: push {cur_sym,cur_cnt}, cur_sym<=in_sym, cur_cnt<=1, stay RUN.
REQ-021 RUN + flush: push {cur_sym,cur_cnt}, go IDLE, provided occupancy<DEPTH; else hold RUN and retry each cycle flush stays high.
REQ-022 IDLE + flush: no action, no record.
REQ-023 At most one record SHALL be pushed per cycle; flush blocks acceptance (REQ-015), so accept and flush never coincide.
REQ-024 Records SHALL leave in push order; a pushed record SHALL appear on out_valid/out_data the cycle after the push.
REQ-025 FIFO pop SHALL occur when out_valid && out_ready; simultaneous push and pop SHALL keep occupancy unchanged and be legal at occupancy DEPTH-1 and DEPTH (pop side).
REQ-026 out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-027 in_valid without in_ready SHALL change no state; in_sym is ignored.
REQ-028 A run count SHALL never be 0 in any emitted record.

Reset
REQ-029 While reset is high at a clock edge: state<=IDLE, cur_cnt<=0, cur_sym<=0, FIFO emptied.
REQ-030 Outputs during/after reset: out_valid=0, out_data=0, busy=0, in_ready=0 while reset high, 1 in first cycle after (flush low).
REQ-031 Reset mid-run or with records queued SHALL discard the open run and all queued records without emitting them.
REQ-032 Reset SHALL take priority over accept, flush and pop on the same edge.

Verification
REQ-033 Defaults, out_ready=1: accept A,A,A,B then flush -> records {A,3} then {B,1}, busy low after last pop.
REQ-034 CNT_W=2: accept A x5, flush -> records {A,3}, {A,2}; no record with count 0 or wrapped value.
REQ-035 DEPTH=4, out_ready=0: accept A,B,C,D,E,F -> after 4 pushes ({A,1}..{D,1}) in_ready=0, F held off; raise out_ready -> {A,1} out, in_ready returns 1 next cycle, order preserved.
REQ-036 flush high with FIFO full and run open -> no push, in_ready=0; one pop -> {open sym,cnt} pushed, state IDLE.
REQ-037 Accept A,A,B (B open, {A,2} queued, out_ready=0), assert reset one cycle -> out_valid=0, busy=0; next accept C, flush -> only {C,1} emitted.
REQ-038 in_valid pulsed with in_ready=0 (flush high) and IDLE+flush -> no state change, no records.
